// File: rtl/ps2_mouse_rx.sv
// PS/2 mouse receiver: filtered device clock, 11-bit frame deserialiser, 3-byte packet assembly.
// Optional odd-parity checking is enabled by defining PS2_MOUSE_RX_PARITY_EN.
module ps2_mouse_rx #(
  parameter int          FILTER_LEN = 8,
  parameter logic [15:0] TIMEOUT    = 16'd20000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ps2_clk,
  input  logic        ps2_dat,
  output logic [24:0] ps2_mouse,
  output logic        frame_err
);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  localparam logic [3:0] FLT_MAX = 4'(FILTER_LEN - 1);

  logic        clk_meta_q, clk_sync_q, dat_meta_q, dat_sync_q;
  logic        filt_q, filt_d;
  logic [3:0]  flt_cnt_q, flt_cnt_d;
  logic        fall_q, fall_d;
  logic [15:0] to_cnt_q;
  state_t      state_q;
  logic [3:0]  bit_cnt_q;
  logic [7:0]  shift_q;
  logic [1:0]  idx_q;
  logic [7:0]  byte0_q, byte1_q;
  logic [24:0] mouse_q;
  logic        err_q;
  logic        to_fire;
  logic        par_ok;

`ifdef PS2_MOUSE_RX_PARITY_EN
  logic par_q;
  assign par_ok = ^{par_q, shift_q};
`else
  assign par_ok = 1'b1;
`endif

  // The filtered level flips only after FILTER_LEN consecutive samples disagree with it.
  always_comb begin
    filt_d    = filt_q;
    flt_cnt_d = flt_cnt_q;
    if (clk_sync_q == filt_q) begin
      flt_cnt_d = 4'd0;
    end else if (flt_cnt_q == FLT_MAX) begin
      filt_d    = clk_sync_q;
      flt_cnt_d = 4'd0;
    end else begin
      flt_cnt_d = flt_cnt_q + 4'd1;
    end
    fall_d = filt_q & ~filt_d;
  end

  assign to_fire = (to_cnt_q == TIMEOUT) && ((state_q != IDLE) || (idx_q != 2'd0));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      clk_meta_q <= 1'b1;
      clk_sync_q <= 1'b1;
      dat_meta_q <= 1'b1;
      dat_sync_q <= 1'b1;
      filt_q     <= 1'b1;
      flt_cnt_q  <= 4'd0;
      fall_q     <= 1'b0;
      to_cnt_q   <= 16'd0;
    end else begin
      clk_meta_q <= ps2_clk;
      clk_sync_q <= clk_meta_q;
      dat_meta_q <= ps2_dat;
      dat_sync_q <= dat_meta_q;
      filt_q     <= filt_d;
      flt_cnt_q  <= flt_cnt_d;
      fall_q     <= fall_d;
      if (fall_q)
        to_cnt_q <= 16'd0;
      else if (to_cnt_q != TIMEOUT)
        to_cnt_q <= to_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= 4'd0;
      shift_q   <= 8'd0;
      idx_q     <= 2'd0;
      byte0_q   <= 8'd0;
      byte1_q   <= 8'd0;
      mouse_q   <= 25'd0;
      err_q     <= 1'b0;
`ifdef PS2_MOUSE_RX_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      err_q <= 1'b0;
      // A timeout coinciding with a fall takes priority; the fall is dropped.
      if (to_fire) begin
        err_q   <= 1'b1;
        state_q <= IDLE;
        idx_q   <= 2'd0;
      end else if (fall_q) begin
        case (state_q)
          IDLE: begin
            if (!dat_sync_q) begin
              state_q   <= DATA;
              bit_cnt_q <= 4'd0;
            end else begin
              err_q <= 1'b1;
              idx_q <= 2'd0;
            end
          end
          DATA: begin
            shift_q   <= {dat_sync_q, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7)
              state_q <= PARITY;
          end
          PARITY: begin
`ifdef PS2_MOUSE_RX_PARITY_EN
            par_q <= dat_sync_q;
`endif
            state_q <= STOP;
          end
          default: begin
            state_q <= IDLE;
            if (!dat_sync_q || !par_ok || ((idx_q == 2'd0) && !shift_q[3])) begin
              err_q <= 1'b1;
              idx_q <= 2'd0;
            end else begin
              case (idx_q)
                2'd0: begin
                  byte0_q <= shift_q;
                  idx_q   <= 2'd1;
                end
                2'd1: begin
                  byte1_q <= shift_q;
                  idx_q   <= 2'd2;
                end
                default: begin
                  mouse_q <= {~mouse_q[24], shift_q, byte1_q, byte0_q};
                  idx_q   <= 2'd0;
                end
              endcase
            end
          end
        endcase
      end
    end
  end

  assign ps2_mouse = mouse_q;
  assign frame_err = err_q;

endmodule
